// File: rtl/ws_systolic_nxn_if.sv
// rtl/ws_systolic_nxn_if.sv - weight/activation/result handshake bundle for ws_systolic_nxn
interface ws_systolic_nxn_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int BW   = 8,
    parameter int AW   = 32
);
    logic                 wt_valid;
    logic                 wt_ready;
    logic [COLS*BW-1:0]   wt_in;
    logic                 act_valid;
    logic                 act_ready;
    logic [ROWS*BW-1:0]   act_in;
    logic                 flush;
    logic                 res_valid;
    logic                 res_ready;
    logic [COLS*AW-1:0]   res_out;
    logic                 busy;
    logic [1:0]           state_o;

    modport master (
        output wt_valid, wt_in, act_valid, act_in, flush, res_ready,
        input  wt_ready, act_ready, res_valid, res_out, busy, state_o
    );

    modport slave (
        input  wt_valid, wt_in, act_valid, act_in, flush, res_ready,
        output wt_ready, act_ready, res_valid, res_out, busy, state_o
    );
endinterface

// File: rtl/ws_systolic_nxn.sv
// rtl/ws_systolic_nxn.sv - weight-stationary ROWS x COLS systolic MAC array with sequencer
// Vector accepted at edge t appears on res_out at edge t+ROWS+COLS; one global stall freezes the datapath.
module ws_systolic_nxn #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int BW     = 8,
    parameter int AW     = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ws_systolic_nxn_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int LW = $clog2(ROWS + 1);
    localparam int IW = $clog2(ROWS + COLS + 2) + 1;
    localparam int VL = ROWS + COLS + 1;

    state_t             state_q, state_d;
    logic [LW-1:0]      ld_cnt_q, ld_cnt_d;
    logic [IW-1:0]      inflight_q, inflight_d;
    logic [VL-1:0]      vld_q;
    logic               stall;
    logic               wt_hs;
    logic               act_hs;
    logic               res_hs;

    logic [BW-1:0]      act_w  [ROWS][COLS];
    logic [BW-1:0]      wt_w   [ROWS][COLS];
    logic [AW-1:0]      psum_w [ROWS][COLS];
    logic [AW-1:0]      res_col [COLS];
    logic [COLS*AW-1:0] res_flat;

    assign stall         = vld_q[VL-1] & ~bus.res_ready;
    assign wt_hs         = bus.wt_valid & bus.wt_ready;
    assign act_hs        = bus.act_valid & bus.act_ready;
    assign res_hs        = bus.res_valid & bus.res_ready;

    assign bus.wt_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign bus.act_ready = (state_q == COMPUTE) && !stall;
    assign bus.res_valid = vld_q[VL-1];
    assign bus.res_out   = res_flat;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        case (state_q)
            IDLE: begin
                if (wt_hs) begin
                    if (ROWS == 1) begin
                        state_d = COMPUTE;
                    end else begin
                        state_d  = LOAD;
                        ld_cnt_d = LW'(1);
                    end
                end
            end
            LOAD: begin
                if (bus.flush) begin
                    state_d  = IDLE;
                    ld_cnt_d = '0;
                end else if (wt_hs) begin
                    if (ld_cnt_q == LW'(ROWS - 1)) begin
                        state_d  = COMPUTE;
                        ld_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && !vld_q[VL-1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (act_hs && !res_hs) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!act_hs && res_hs) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    // The valid bit rides alongside the wavefront; its last stage is res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= {vld_q[VL-2:0], act_hs};
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [BW-1:0] sk_q [r+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) sk_q[k] <= '0;
            end else if (!stall) begin
                sk_q[0] <= act_hs ? bus.act_in[r*BW +: BW] : '0;
                for (int k = 1; k <= r; k++) sk_q[k] <= sk_q[k-1];
            end
        end

        assign act_w[r][0] = sk_q[r];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [BW-1:0]   w_q;
            logic [BW-1:0]   w_src;
            logic [AW-1:0]   ps_q;
            logic [AW-1:0]   ps_in;
            logic [2*BW-1:0] a_x, w_x, p_x;
            logic [AW-1:0]   prod;

            assign wt_w[r][c]   = w_q;
            assign psum_w[r][c] = ps_q;

            // Weight beats enter row 0 and shift down, so the first beat settles in the bottom row.
            if (r == 0) begin : g_top
                assign w_src = bus.wt_in[c*BW +: BW];
                assign ps_in = '0;
            end else begin : g_below
                assign w_src = wt_w[r-1][c];
                assign ps_in = psum_w[r-1][c];
            end

            always_comb begin
                if (SIGNED) begin
                    a_x  = {{BW{act_w[r][c][BW-1]}}, act_w[r][c]};
                    w_x  = {{BW{w_q[BW-1]}}, w_q};
                    p_x  = a_x * w_x;
                    prod = AW'($signed(p_x));
                end else begin
                    a_x  = {{BW{1'b0}}, act_w[r][c]};
                    w_x  = {{BW{1'b0}}, w_q};
                    p_x  = a_x * w_x;
                    prod = AW'(p_x);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_q <= '0;
                end else if (wt_hs) begin
                    w_q <= w_src;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ps_q <= '0;
                end else if (!stall) begin
                    ps_q <= ps_in + prod;
                end
            end

            if (c < COLS - 1) begin : g_pass
                logic [BW-1:0] a_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                    end else if (!stall) begin
                        a_q <= act_w[r][c];
                    end
                end

                assign act_w[r][c+1] = a_q;
            end
        end
    end

    // Column c leaves the array c cycles late; COLS-c stages realign it, the last one being res_out.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int DL = COLS - c;
        logic [AW-1:0] ds_q [DL];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DL; k++) ds_q[k] <= '0;
            end else if (!stall) begin
                ds_q[0] <= psum_w[ROWS-1][c];
                for (int k = 1; k < DL; k++) ds_q[k] <= ds_q[k-1];
            end
        end

        assign res_col[c] = ds_q[DL-1];
    end

    always_comb begin
        res_flat = '0;
        for (int c = 0; c < COLS; c++) res_flat[c*AW +: AW] = res_col[c];
    end
endmodule

// File: tb/tb_ws_systolic_nxn.sv
// tb/tb_ws_systolic_nxn.sv - randomized self-checking bench for ws_systolic_nxn
module tb_ws_systolic_nxn;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int BW     = 8;
    localparam int AW     = 32;
    localparam bit SIGNED = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws_systolic_nxn_if #(.ROWS(ROWS), .COLS(COLS), .BW(BW), .AW(AW)) bus ();

    ws_systolic_nxn #(.ROWS(ROWS), .COLS(COLS), .BW(BW), .AW(AW), .SIGNED(SIGNED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [BW-1:0]      wm [ROWS][COLS];
    logic [COLS*AW-1:0] exp_q [$];
    logic [COLS*AW-1:0] got_q [$];
    int                 acc_cyc [$];
    int                 got_cyc [$];

    function automatic longint ext(input logic [BW-1:0] v);
        if (SIGNED) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic logic [COLS*AW-1:0] model(input logic [ROWS*BW-1:0] a);
        logic [COLS*AW-1:0] res;
        longint             s;
        logic [63:0]        su;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) s += ext(a[r*BW +: BW]) * ext(wm[r][c]);
            su = s;
            res[c*AW +: AW] = su[AW-1:0];
        end
        return res;
    endfunction

    function automatic logic [ROWS*BW-1:0] rand_act();
        logic [ROWS*BW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bus.act_valid && bus.act_ready) begin
            exp_q.push_back(model(bus.act_in));
            acc_cyc.push_back(cyc + 1);
        end
        if (bus.res_valid && bus.res_ready) begin
            got_q.push_back(bus.res_out);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
    endtask

    task automatic load_w(input int mode);
        logic [BW-1:0] val;
        int row;
        for (int k = 0; k < ROWS; k++) begin
            row = ROWS - 1 - k;
            for (int c = 0; c < COLS; c++) begin
                if (mode == 0)      val = (row == c) ? BW'(1) : BW'(0);
                else if (mode == 1) val = BW'($urandom);
                else                val = '1;
                bus.wt_in[c*BW +: BW] = val;
                wm[row][c] = val;
            end
            bus.wt_valid = 1'b1;
            tick();
        end
        bus.wt_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        bus.act_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 60 && bus.state_o != 2'd0; i++) tick();
        ok = (bus.state_o == 2'd0);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_out !== '0) begin n_err++; $display("FAIL reset_res_out: got %h want 0", bus.res_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.act_ready !== 1'b0) begin n_err++; $display("FAIL reset_act_ready: got %b want 0", bus.act_ready); end
        n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.wt_ready !== 1'b1) begin n_err++; $display("FAIL reset_wt_ready: got %b want 1", bus.wt_ready); end
    endtask

    task automatic test_identity();
        logic [ROWS*BW-1:0] a;
        logic [COLS*AW-1:0] want;
        bit ok;
        clear_sb();
        load_w(0);
        n_cmp++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL id_state_compute: got %0d want 2", bus.state_o); end
        a = {8'd4, 8'd3, 8'd2, 8'd1};
        want = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.res_ready = 1'b1;
        bus.act_in = a;
        bus.act_valid = 1'b1;
        tick();
        bus.act_valid = 1'b0;
        for (int i = 0; i < 20 && got_q.size() == 0; i++) tick();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL id_count: got %0d results want 1", got_q.size());
        end else begin
            if (got_q[0] !== want) begin n_err++; $display("FAIL id_result: got %h want %h", got_q[0], want); end
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL id_model: got %h want %h", got_q[0], exp_q[0]); end
            n_cmp++; if (got_cyc[0] - acc_cyc[0] != ROWS + COLS) begin n_err++; $display("FAIL id_latency: got %0d want %0d", got_cyc[0] - acc_cyc[0], ROWS + COLS); end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL id_drain: state %0d want 0", bus.state_o); end
    endtask

    task automatic test_stream();
        bit ok;
        clear_sb();
        load_w(1);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.act_in = rand_act();
            bus.act_valid = 1'b1;
            n_cmp++; if (bus.act_ready !== 1'b1) begin n_err++; $display("FAIL stream_act_ready[%0d]: got %b want 1", i, bus.act_ready); end
            tick();
        end
        bus.act_valid = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 4; i++) tick();
        n_cmp++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_err++; $display("FAIL stream_count: got %0d results want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stream_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
                n_cmp++; if (got_cyc[i] != got_cyc[0] + i) begin n_err++; $display("FAIL stream_consecutive[%0d]: got cyc %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
                n_cmp++; if (got_cyc[i] - acc_cyc[i] != ROWS + COLS) begin n_err++; $display("FAIL stream_latency[%0d]: got %0d want %0d", i, got_cyc[i] - acc_cyc[i], ROWS + COLS); end
            end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stream_drain: state %0d want 0", bus.state_o); end
    endtask

    task automatic test_backpressure();
        logic [ROWS*BW-1:0] v;
        logic [COLS*AW-1:0] prev;
        bit stl, ok;
        int sent, stalls;
        clear_sb();
        load_w(1);
        sent = 0; stalls = 0;
        v = rand_act();
        for (int i = 0; i < 40; i++) begin
            bus.res_ready = !(i >= 10 && i < 13);
            bus.act_valid = (sent < 8);
            bus.act_in = v;
            #1;
            stl = bus.res_valid && !bus.res_ready;
            prev = bus.res_out;
            if (stl) begin
                stalls++;
                n_cmp++; if (bus.act_ready !== 1'b0) begin n_err++; $display("FAIL bp_act_ready[%0d]: got %b want 0", i, bus.act_ready); end
            end
            tick();
            if (stl) begin
                n_cmp++; if (bus.res_out !== prev || bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got %h v%b want %h v1", i, bus.res_out, bus.res_valid, prev); end
            end
            if (exp_q.size() > sent) begin
                sent++;
                v = rand_act();
            end
        end
        bus.act_valid = 1'b0;
        n_cmp++; if (stalls != 3) begin n_err++; $display("FAIL bp_stall_cycles: got %0d want 3", stalls); end
        n_cmp++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            n_err++; $display("FAIL bp_count: got %0d results want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_drain: state %0d want 0", bus.state_o); end
    endtask

    task automatic test_signed();
        logic [COLS*AW-1:0] r0;
        logic [AW-1:0] col;
        logic [AW-1:0] want;
        bit ok;
        clear_sb();
        load_w(2);
        want = 32'hFFFF_FE04;
        bus.res_ready = 1'b1;
        bus.act_in = {ROWS{8'h7F}};
        bus.act_valid = 1'b1;
        tick();
        bus.act_valid = 1'b0;
        for (int i = 0; i < 20 && got_q.size() == 0; i++) tick();
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL signed_count: got %0d results want 1", got_q.size());
        end else begin
            r0 = got_q[0];
            for (int c = 0; c < COLS; c++) begin
                col = r0[c*AW +: AW];
                n_cmp++; if (col !== want) begin n_err++; $display("FAIL signed_col[%0d]: got %h want %h", c, col, want); end
            end
            n_cmp++; if (r0 !== exp_q[0]) begin n_err++; $display("FAIL signed_model: got %h want %h", r0, exp_q[0]); end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL signed_drain: state %0d want 0", bus.state_o); end
    endtask

    task automatic test_flush();
        clear_sb();
        load_w(1);
        bus.res_ready = 1'b0;
        bus.act_in = rand_act();
        bus.act_valid = 1'b1;
        tick();
        bus.act_in = rand_act();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.act_valid = 1'b0;
        n_cmp++; if (exp_q.size() != 2) begin n_err++; $display("FAIL flush_accepted: got %0d want 2", exp_q.size()); end
        n_cmp++; if (bus.state_o !== 2'd3 || bus.busy !== 1'b1) begin n_err++; $display("FAIL flush_drain_state: got %0d busy %b want 3 busy 1", bus.state_o, bus.busy); end
        repeat (12) tick();
        n_cmp++; if (bus.state_o !== 2'd3 || bus.act_ready !== 1'b0 || bus.res_valid !== 1'b1) begin n_err++; $display("FAIL flush_held: got st %0d ar %b rv %b want st 3 ar 0 rv 1", bus.state_o, bus.act_ready, bus.res_valid); end
        bus.res_ready = 1'b1;
        for (int i = 0; i < 30 && bus.state_o != 2'd0; i++) tick();
        n_cmp++; if (bus.state_o !== 2'd0 || bus.busy !== 1'b0 || bus.wt_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got st %0d busy %b wr %b want st 0 busy 0 wr 1", bus.state_o, bus.busy, bus.wt_ready); end
        n_cmp++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_err++; $display("FAIL flush_count: got %0d results want 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL flush_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_load_abort();
        logic [BW-1:0] val;
        bit ok;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL idle_flush_ignored: got %0d want 0", bus.state_o); end
        bus.wt_in = '0;
        bus.wt_valid = 1'b1;
        tick(); tick();
        bus.wt_valid = 1'b0;
        n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL abort_in_load: got %0d want 1", bus.state_o); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.state_o !== 2'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %0d busy %b want 0 busy 0", bus.state_o, bus.busy); end
        for (int k = 0; k < ROWS; k++) begin
            for (int c = 0; c < COLS; c++) begin
                val = BW'($urandom);
                bus.wt_in[c*BW +: BW] = val;
                wm[ROWS-1-k][c] = val;
            end
            bus.wt_valid = 1'b1;
            tick();
            if (k == ROWS - 2) begin
                n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL abort_counter_cleared: got %0d want 1", bus.state_o); end
            end
        end
        bus.wt_valid = 1'b0;
        n_cmp++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL reload_compute: got %0d want 2", bus.state_o); end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_drain: state %0d want 0", bus.state_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        load_w(1);
        bus.res_ready = 1'b0;
        bus.act_in = rand_act();
        bus.act_valid = 1'b1;
        tick();
        bus.act_valid = 1'b0;
        for (int i = 0; i < 20 && bus.res_valid !== 1'b1; i++) tick();
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", bus.res_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.res_out !== '0) begin n_err++; $display("FAIL rstmid_outputs: got v%b %h want v0 0", bus.res_valid, bus.res_out); end
        n_cmp++; if (bus.state_o !== 2'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_state: got %0d busy %b want 0 busy 0", bus.state_o, bus.busy); end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.wt_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_wt_ready: got %b want 1", bus.wt_ready); end
        clear_sb();
        load_w(1);
        bus.res_ready = 1'b1;
        bus.act_in = rand_act();
        bus.act_valid = 1'b1;
        tick();
        bus.act_valid = 1'b0;
        for (int i = 0; i < 20 && got_q.size() == 0; i++) tick();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL rstmid_after_count: got %0d results want 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL rstmid_after_result: got %h want %h", got_q[0], exp_q[0]);
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_drain: state %0d want 0", bus.state_o); end
    endtask

    initial begin
        bus.wt_valid  = 1'b0;
        bus.wt_in     = '0;
        bus.act_valid = 1'b0;
        bus.act_in    = '0;
        bus.flush     = 1'b0;
        bus.res_ready = 1'b0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = '0;
        test_reset();
        test_identity();
        test_stream();
        test_backpressure();
        test_signed();
        test_flush();
        test_load_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
